enemy_spawn_ctrl: RTL

Frame-rate scheduler that owns the life cycle of every enemy tank instance. It tracks which enemies are alive and runs a respawn cooldown for each destroyed enemy. It shares a small set of spawn points between the enemies that are waiting, using round-robin, and issues one spawn command per frame. It sits between the enemy instances and the top-level game logic: its spawn pulses and coordinates drive the enemies' location-reset path.

---
 rtl/enemy_spawn_ctrl_pkg.sv | 7 +
 rtl/enemy_spawn_ctrl_if.sv | 25 ++
 rtl/enemy_spawn_ctrl_rr_arbiter.sv | 25 ++
 rtl/enemy_spawn_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/enemy_spawn_ctrl_pkg.sv
// enemy_pkg: enemy life-cycle state type, spawn-point coordinate table and coordinate width
package enemy_pkg;
  localparam int COORD_W = 10;
  typedef enum logic [1:0] {DEAD_COOL, READY, ALIVE} enemy_state_t;
  localparam logic [COORD_W-1:0] SPAWN_X [4] = '{10'd32, 10'd304, 10'd576, 10'd304};
  localparam logic [COORD_W-1:0] SPAWN_Y [4] = '{10'd32, 10'd32, 10'd32, 10'd224};
endpackage

// File: rtl/enemy_spawn_ctrl_if.sv
// enemy_spawn_ctrl_if: frame events in, spawn commands and enemy status out
interface enemy_spawn_ctrl_if #(
  parameter int N_ENEMY = 2,
  parameter int N_SPAWN = 3
);
  import enemy_pkg::*;
  logic               refresh_tick;
  logic [N_ENEMY-1:0] enemy_killed;
  logic               tank_detroyed;
  logic [N_SPAWN-1:0] spawn_busy;
  logic [N_ENEMY-1:0] spawn_go;
  logic [COORD_W-1:0] spawn_x;
  logic [COORD_W-1:0] spawn_y;
  logic [N_ENEMY-1:0] alive;
  logic [7:0]         kills;
  logic               wave_clear;
  modport master (
    output refresh_tick, enemy_killed, tank_detroyed, spawn_busy,
    input  spawn_go, spawn_x, spawn_y, alive, kills, wave_clear
  );
  modport slave (
    input  refresh_tick, enemy_killed, tank_detroyed, spawn_busy,
    output spawn_go, spawn_x, spawn_y, alive, kills, wave_clear
  );
endinterface

// File: rtl/enemy_spawn_ctrl_rr_arbiter.sv
// rr_arbiter: first set request searching upward with wrap from a start pointer
module rr_arbiter #(
  parameter int W = 2,
  localparam int IW = W > 1 ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [W-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  // scan from farthest to nearest so the nearest request after ptr is the last one written
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = W - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % W]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % W] = 1'b1;
        idx = IW'((int'(ptr) + k) % W);
        any = 1'b1;
      end
  end
endmodule

// File: rtl/enemy_spawn_ctrl.sv
// enemy_spawn_ctrl: per-frame enemy respawn scheduler; ENEMY_SPAWN_LIMIT_EN enables a per-wave spawn budget
module enemy_spawn_ctrl
  import enemy_pkg::*;
#(
  parameter int N_ENEMY       = 2,
  parameter int N_SPAWN       = 3,
  parameter int RESPAWN_TICKS = 60
`ifdef ENEMY_SPAWN_LIMIT_EN
  , parameter int MAX_SPAWNS  = 20
`endif
) (
  input logic               clk_50MHz,
  input logic               reset,
  enemy_spawn_ctrl_if.slave bus
);
  localparam int EW = N_ENEMY > 1 ? $clog2(N_ENEMY) : 1;
  localparam int SW = N_SPAWN > 1 ? $clog2(N_SPAWN) : 1;
  enemy_state_t       state [N_ENEMY];
  logic [7:0]         cool  [N_ENEMY];
  logic [EW-1:0]      enemy_ptr, enemy_idx;
  logic [SW-1:0]      sp_ptr, sp_idx;
  logic [N_ENEMY-1:0] ready, accepted, enemy_gnt;
  logic [N_SPAWN-1:0] sp_gnt;
  logic [COORD_W-1:0] sp_x, sp_y;
  logic [8:0]         kill_sum;
  logic               enemy_any, sp_any, budget_ok, grant;

  // per-enemy eligibility and accepted kills (only a live enemy can be killed)
  always_comb begin
    ready    = '0;
    accepted = '0;
    for (int i = 0; i < N_ENEMY; i++) begin
      ready[i]    = state[i] == READY;
      accepted[i] = bus.enemy_killed[i] && state[i] == ALIVE;
    end
  end

  rr_arbiter #(.W(N_ENEMY)) u_enemy_arb (
    .req(ready), .ptr(enemy_ptr), .gnt(enemy_gnt), .idx(enemy_idx), .any(enemy_any)
  );

  rr_arbiter #(.W(N_SPAWN)) u_sp_arb (
    .req(~bus.spawn_busy), .ptr(sp_ptr), .gnt(sp_gnt), .idx(sp_idx), .any(sp_any)
  );

  // one-hot select of the granted spawn point's coordinates
  always_comb begin
    sp_x = '0;
    sp_y = '0;
    for (int j = 0; j < N_SPAWN; j++) begin
      sp_x = sp_x | (sp_gnt[j] ? SPAWN_X[j] : '0);
      sp_y = sp_y | (sp_gnt[j] ? SPAWN_Y[j] : '0);
    end
  end

`ifdef ENEMY_SPAWN_LIMIT_EN
  logic [7:0] spawns_left;
  assign budget_ok = spawns_left != 8'd0;
  // wave budget counts down per grant; wave is clear once spent and the field is empty
  always_ff @(posedge clk_50MHz or negedge reset)
    if (!reset) begin
      spawns_left    <= 8'(MAX_SPAWNS);
      bus.wave_clear <= 1'b0;
    end else begin
      spawns_left    <= grant ? spawns_left - 8'd1 : spawns_left;
      bus.wave_clear <= spawns_left == 8'd0 && bus.alive == '0;
    end
`else
  assign budget_ok      = 1'b1;
  assign bus.wave_clear = 1'b0;
`endif

  assign grant    = bus.refresh_tick && !bus.tank_detroyed && budget_ok && enemy_any && sp_any;
  assign kill_sum = 9'(bus.kills) + 9'($countones(accepted));

  // enemy life-cycle FSMs, round-robin pointers and registered outputs
  always_ff @(posedge clk_50MHz or negedge reset)
    if (!reset) begin
      for (int i = 0; i < N_ENEMY; i++) begin
        state[i] <= READY;
        cool[i]  <= 8'd0;
      end
      enemy_ptr    <= '0;
      sp_ptr       <= '0;
      bus.spawn_go <= '0;
      bus.spawn_x  <= '0;
      bus.spawn_y  <= '0;
      bus.alive    <= '0;
      bus.kills    <= '0;
    end else begin
      for (int i = 0; i < N_ENEMY; i++) begin
        if (accepted[i]) begin
          state[i] <= RESPAWN_TICKS == 0 ? READY : DEAD_COOL;
          cool[i]  <= 8'(RESPAWN_TICKS);
        end else if (state[i] == DEAD_COOL && bus.refresh_tick) begin
          cool[i]  <= cool[i] - 8'd1;
          state[i] <= cool[i] == 8'd1 ? READY : DEAD_COOL;
        end else if (grant && enemy_gnt[i]) begin
          state[i] <= ALIVE;
        end
        bus.alive[i] <= (grant && enemy_gnt[i]) || (state[i] == ALIVE && !bus.enemy_killed[i]);
      end
      if (grant) begin
        enemy_ptr <= enemy_idx == EW'(N_ENEMY - 1) ? '0 : enemy_idx + 1'b1;
        sp_ptr    <= sp_idx == SW'(N_SPAWN - 1) ? '0 : sp_idx + 1'b1;
      end
      bus.spawn_go <= grant ? enemy_gnt : '0;
      bus.spawn_x  <= grant ? sp_x : '0;
      bus.spawn_y  <= grant ? sp_y : '0;
      bus.kills    <= kill_sum[8] ? 8'hff : kill_sum[7:0];
    end
endmodule
